// File: rtl/arith_combine_pipe.sv
// arith_combine_pipe: two-stage valid/ready pipeline computing
// (A+B) - (A-B) + A*B modulo 2^NX, with sum, difference and accumulate modes.
// Stage 1 registers the three partial terms; stage 2 combines them, selects
// the result by mode and maintains the accumulator. A skid-free stall scheme
// (en2/en1) gives full throughput and holds the output stable under backpressure.
module arith_combine_pipe #(
    parameter int NX = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [NX-1:0] A,
    input  logic [NX-1:0] B,
    input  logic [1:0]    MODE,
    input  logic          CLR,
    input  logic          IVALID,
    output logic          IRDY,
    output logic [NX-1:0] XOUT,
    output logic          OVALID,
    input  logic          ORDY
);

    typedef enum logic [1:0] {
        M_COMBINE = 2'd0,
        M_SUM     = 2'd1,
        M_DIFF    = 2'd2,
        M_ACC     = 2'd3
    } mode_e;

    // Stage 1 registers
    logic          s1_valid_q;
    logic [NX-1:0] s1_sum_q, s1_diff_q, s1_prod_q;
    logic [1:0]    s1_mode_q;
    logic          s1_clr_q;

    // Stage 2 registers
    logic          ovalid_q;
    logic [NX-1:0] xout_q;
    logic [NX-1:0] acc_q;

    // Stage enables and stage 1 next-state terms
    logic          en1, en2;
    logic [2*NX-1:0] prod_w;
    logic [NX-1:0] sum_d, diff_d, prod_d;

    // Stage 2 next-state terms
    logic [NX-1:0] comb_d, base_d, res_d, acc_d;

    // Stage 2 may load whenever it is empty or its result is being taken;
    // stage 1 may load whenever it is empty or it drains into stage 2.
    assign en2  = ~ovalid_q | ORDY;
    assign en1  = ~s1_valid_q | en2;
    assign IRDY = en1;

    assign XOUT   = xout_q;
    assign OVALID = ovalid_q;

    // Full-width product, only the low NX bits are kept.
    assign prod_w = {{NX{1'b0}}, A} * {{NX{1'b0}}, B};
    assign sum_d  = A + B;
    assign diff_d = A - B;
    assign prod_d = prod_w[NX-1:0];

    // Stage 1 register: capture partial terms and controls on accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_diff_q  <= '0;
            s1_prod_q  <= '0;
            s1_mode_q  <= 2'd0;
            s1_clr_q   <= 1'b0;
        end else if (en1) begin
            s1_valid_q <= IVALID;
            if (IVALID) begin
                s1_sum_q  <= sum_d;
                s1_diff_q <= diff_d;
                s1_prod_q <= prod_d;
                s1_mode_q <= MODE;
                s1_clr_q  <= CLR;
            end
        end
    end

    // Stage 2 datapath: combine, mode select and accumulator next value
    always_comb begin
        comb_d = s1_sum_q - s1_diff_q + s1_prod_q;
        base_d = s1_clr_q ? '0 : acc_q;
        res_d  = comb_d;
        acc_d  = s1_clr_q ? '0 : acc_q;
        case (mode_e'(s1_mode_q))
            M_COMBINE: res_d = comb_d;
            M_SUM:     res_d = s1_sum_q;
            M_DIFF:    res_d = s1_diff_q;
            M_ACC: begin
                res_d = base_d + comb_d;
                acc_d = base_d + comb_d;
            end
            default:   res_d = comb_d;
        endcase
    end

    // Stage 2 register: result and accumulator advance once per beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovalid_q <= 1'b0;
            xout_q   <= '0;
            acc_q    <= '0;
        end else if (en2) begin
            ovalid_q <= s1_valid_q;
            if (s1_valid_q) begin
                xout_q <= res_d;
                acc_q  <= acc_d;
            end
        end
    end

endmodule

// File: tb/tb_arith_combine_pipe.sv
// Directed bench for arith_combine_pipe: NX=8 instance for mode, accumulate,
// backpressure and reset scenarios; NX=12 instance for wider wraparound.
module tb_arith_combine_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  A, B;
    logic [1:0]  MODE;
    logic        CLR, IVALID, IRDY, OVALID, ORDY;
    logic [7:0]  XOUT;

    logic [11:0] A12, B12, XOUT12;
    logic [1:0]  MODE12;
    logic        CLR12, IVALID12, IRDY12, OVALID12, ORDY12;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    arith_combine_pipe #(.NX(8)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .MODE(MODE), .CLR(CLR),
        .IVALID(IVALID), .IRDY(IRDY), .XOUT(XOUT), .OVALID(OVALID), .ORDY(ORDY)
    );

    arith_combine_pipe #(.NX(12)) dut12 (
        .CLK(CLK), .RST(RST), .A(A12), .B(B12), .MODE(MODE12), .CLR(CLR12),
        .IVALID(IVALID12), .IRDY(IRDY12), .XOUT(XOUT12), .OVALID(OVALID12),
        .ORDY(ORDY12)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Push one beat into an empty NX=8 pipe with ORDY=1 and report what came out.
    task automatic one_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] m, input logic c,
                            output logic [7:0] x, output logic v_early,
                            output logic v);
        ORDY = 1'b1;
        A = a; B = b; MODE = m; CLR = c; IVALID = 1'b1;
        tick();
        IVALID = 1'b0; CLR = 1'b0;
        v_early = OVALID;
        tick();
        v = OVALID;
        x = XOUT;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        vectors++;
        if (OVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovalid: got %b expected 0", OVALID);
        end
        vectors++;
        if (XOUT !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_xout: got %h expected 00", XOUT);
        end
        vectors++;
        if (IRDY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_irdy: got %b expected 1", IRDY);
        end
    endtask

    task automatic test_modes();
        logic [7:0] a_t[4] = '{8'd3, 8'd200, 8'd200, 8'd3};
        logic [7:0] b_t[4] = '{8'd5, 8'd100, 8'd100, 8'd5};
        logic [1:0] m_t[4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic [7:0] e_t[4] = '{8'h19, 8'hE8, 8'h2C, 8'hFE};
        logic [7:0] x;
        logic ve, v;
        for (int i = 0; i < 4; i++) begin
            one_beat(a_t[i], b_t[i], m_t[i], 1'b0, x, ve, v);
            vectors++;
            if (ve !== 1'b0 || v !== 1'b1) begin
                miscompares++;
                $display("FAIL mode_latency[%0d]: got early=%b valid=%b expected early=0 valid=1", i, ve, v);
            end
            vectors++;
            if (x !== e_t[i]) begin
                miscompares++;
                $display("FAIL mode_result[%0d]: got %h expected %h", i, x, e_t[i]);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [1:0] m_t[7] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        logic       c_t[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] e_t[7] = '{8'd25, 8'd50, 8'd75, 8'd25, 8'd100, 8'd25, 8'd25};
        logic [7:0] x;
        logic ve, v;
        for (int i = 0; i < 7; i++) begin
            one_beat(8'd3, 8'd5, m_t[i], c_t[i], x, ve, v);
            vectors++;
            if (v !== 1'b1 || x !== e_t[i]) begin
                miscompares++;
                $display("FAIL acc_result[%0d]: got valid=%b x=%0d expected valid=1 x=%0d", i, v, x, e_t[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a_t[4] = '{8'd3, 8'd1, 8'd2, 8'd3};
        logic [7:0] b_t[4] = '{8'd5, 8'd1, 8'd3, 8'd5};
        logic [1:0] m_t[4] = '{2'd3, 2'd3, 2'd3, 2'd0};
        logic       c_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] e_t[4] = '{8'd25, 8'd28, 8'd40, 8'd25};
        int idx = 0;
        int n = 0;
        logic in_fire, out_fire;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            ORDY = (cyc >= 5);
            if (idx < 4) begin
                A = a_t[idx]; B = b_t[idx]; MODE = m_t[idx]; CLR = c_t[idx];
                IVALID = 1'b1;
            end else begin
                IVALID = 1'b0; CLR = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc < 5) begin
                vectors++;
                if (IRDY !== 1'b0 || OVALID !== 1'b1 || XOUT !== 8'd25) begin
                    miscompares++;
                    $display("FAIL bp_stall[%0d]: got irdy=%b ovalid=%b x=%0d expected irdy=0 ovalid=1 x=25", cyc, IRDY, OVALID, XOUT);
                end
            end
            if (cyc == 5) begin
                vectors++;
                if (IRDY !== 1'b1 || idx !== 2) begin
                    miscompares++;
                    $display("FAIL bp_release: got irdy=%b accepted=%0d expected irdy=1 accepted=2", IRDY, idx);
                end
            end
            out_fire = OVALID & ORDY;
            in_fire  = IVALID & IRDY;
            if (out_fire) begin
                vectors++;
                if (XOUT !== e_t[n]) begin
                    miscompares++;
                    $display("FAIL bp_out[%0d]: got %0d expected %0d", n, XOUT, e_t[n]);
                end
                n++;
            end
            tick();
            if (in_fire) idx++;
        end
        IVALID = 1'b0;
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d results expected 4", n);
        end
        vectors++;
        if (OVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_dup: got ovalid=%b expected 0", OVALID);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] x;
        logic ve, v;
        ORDY = 1'b0;
        A = 8'd3; B = 8'd5; MODE = 2'd3; CLR = 1'b1; IVALID = 1'b1;
        tick();
        CLR = 1'b0;
        tick();
        vectors++;
        if (OVALID !== 1'b1 || XOUT !== 8'd25) begin
            miscompares++;
            $display("FAIL rst_pre: got ovalid=%b x=%0d expected ovalid=1 x=25", OVALID, XOUT);
        end
        RST = 1'b1;
        A = 8'd9; B = 8'd9;
        tick();
        RST = 1'b0;
        IVALID = 1'b0;
        vectors++;
        if (OVALID !== 1'b0 || XOUT !== 8'h00 || IRDY !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: got ovalid=%b x=%h irdy=%b expected 0 00 1", OVALID, XOUT, IRDY);
        end
        ORDY = 1'b1;
        tick();
        vectors++;
        if (OVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drop: got ovalid=%b expected 0", OVALID);
        end
        one_beat(8'd3, 8'd5, 2'd3, 1'b0, x, ve, v);
        vectors++;
        if (v !== 1'b1 || x !== 8'd25) begin
            miscompares++;
            $display("FAIL rst_acc_cleared: got valid=%b x=%0d expected valid=1 x=25", v, x);
        end
    endtask

    task automatic test_nx12_back_to_back();
        logic [11:0] a_t[4] = '{12'd4000, 12'd0, 12'd4095, 12'd4095};
        logic [11:0] b_t[4] = '{12'd100, 12'd1, 12'd1, 12'd4095};
        logic [1:0]  m_t[4] = '{2'd0, 2'd2, 2'd1, 2'd0};
        logic [11:0] e_t[4] = '{12'hB48, 12'hFFF, 12'h000, 12'hFFF};
        ORDY12 = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                A12 = a_t[cyc]; B12 = b_t[cyc]; MODE12 = m_t[cyc]; IVALID12 = 1'b1;
            end else begin
                IVALID12 = 1'b0;
            end
            tick();
            if (cyc >= 1 && cyc <= 4) begin
                vectors++;
                if (OVALID12 !== 1'b1 || XOUT12 !== e_t[cyc-1]) begin
                    miscompares++;
                    $display("FAIL nx12[%0d]: got valid=%b x=%h expected valid=1 x=%h", cyc-1, OVALID12, XOUT12, e_t[cyc-1]);
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        A = '0; B = '0; MODE = '0; CLR = 1'b0; IVALID = 1'b0; ORDY = 1'b1;
        A12 = '0; B12 = '0; MODE12 = '0; CLR12 = 1'b0; IVALID12 = 1'b0; ORDY12 = 1'b1;
        test_reset();
        test_modes();
        test_accumulate();
        test_backpressure();
        test_reset_midstream();
        test_nx12_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
